// File: rtl/touch_swipe_decoder.sv
// Single-finger stroke tracker: follows one touch from touch-down to release and
// classifies it as a W/E/N/S swipe or a tap, with stroke timeout and post-gesture holdoff.
module touch_swipe_decoder #(
    parameter int unsigned SWIPE_MIN      = 60,
    parameter int unsigned TAP_MAX        = 15,
    parameter int unsigned GAP_CYCLES     = 5_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned HOLDOFF_CYCLES = 10_000_000
) (
    input  logic               iCLK,
    input  logic               iRSTN,
    input  logic               iREADY,
    input  logic [3:0]         iTOUCH_COUNT,
    input  logic [9:0]         iX1,
    input  logic [8:0]         iY1,
    output logic               oGEST_W,
    output logic               oGEST_E,
    output logic               oGEST_N,
    output logic               oGEST_S,
    output logic               oGEST_TAP,
    output logic signed [10:0] oDX,
    output logic signed [9:0]  oDY,
    output logic               oBUSY
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRACK,
        ST_EVAL,
        ST_ABORT,
        ST_HOLDOFF
    } state_e;

    state_e state_q, state_d;

    logic              rdy_q;
    logic [9:0]        sx_q, sx_d, lx_q, lx_d;
    logic [8:0]        sy_q, sy_d, ly_q, ly_d;
    logic [31:0]       dur_q, dur_d, gap_q, gap_d, hold_q, hold_d;
    logic signed [10:0] dx_q, dx_d;
    logic signed [9:0]  dy_q, dy_d;
    logic [4:0]        gest_q, gest_d;   // {TAP, S, N, E, W}

    logic              report, cnt_zero, cnt_one, cnt_multi;
    logic              gap_done, dur_done, hold_done;
    logic signed [10:0] diff_x;
    logic signed [9:0]  diff_y;
    logic [31:0]       adx, ady;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    assign report    = iREADY & ~rdy_q;
    assign cnt_zero  = report && (iTOUCH_COUNT == 4'd0);
    assign cnt_one   = report && (iTOUCH_COUNT == 4'd1);
    assign cnt_multi = report && (iTOUCH_COUNT >= 4'd2);

    // Threshold compares use >= so a saturated or overshooting counter still terminates.
    assign gap_done  = gap_q  >= GAP_CYCLES - 1;
    assign dur_done  = dur_q  >= TIMEOUT_CYCLES - 1;
    assign hold_done = hold_q >= HOLDOFF_CYCLES - 1;

    assign diff_x = signed'({1'b0, lx_q}) - signed'({1'b0, sx_q});
    assign diff_y = signed'({1'b0, ly_q}) - signed'({1'b0, sy_q});
    assign adx    = {21'd0, diff_x[10] ? 11'(-diff_x) : 11'(diff_x)};
    assign ady    = {22'd0, diff_y[9]  ? 10'(-diff_y) : 10'(diff_y)};

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (cnt_one) state_d = ST_TRACK;
            ST_TRACK: begin
                if (report) begin
                    if (cnt_zero)       state_d = ST_EVAL;
                    else if (cnt_multi) state_d = ST_ABORT;
                end else if (gap_done) begin
                    state_d = ST_EVAL;
                end else if (dur_done) begin
                    state_d = ST_ABORT;
                end
            end
            ST_EVAL:  state_d = ST_HOLDOFF;
            ST_ABORT: begin
                if (report) begin
                    if (cnt_zero) state_d = ST_HOLDOFF;
                end else if (gap_done) begin
                    state_d = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: if (hold_done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sx_d   = sx_q;
        sy_d   = sy_q;
        lx_d   = lx_q;
        ly_d   = ly_q;
        dur_d  = dur_q;
        gap_d  = gap_q;
        hold_d = '0;
        dx_d   = dx_q;
        dy_d   = dy_q;
        gest_d = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (cnt_one) begin
                    sx_d  = iX1;
                    sy_d  = iY1;
                    lx_d  = iX1;
                    ly_d  = iY1;
                    dur_d = '0;
                    gap_d = '0;
                end
            end
            ST_TRACK: begin
                dur_d = sat_inc(dur_q);
                gap_d = sat_inc(gap_q);
                if (cnt_one) begin
                    lx_d  = iX1;
                    ly_d  = iY1;
                    gap_d = '0;
                end
                // Leaving TRACK: ABORT reuses the gap counter from zero.
                if (state_d != ST_TRACK) gap_d = '0;
            end
            ST_EVAL: begin
                dx_d = diff_x;
                dy_d = diff_y;
                if (adx >= ady && adx >= SWIPE_MIN) begin
                    gest_d = diff_x[10] ? 5'b00001 : 5'b00010;
                end else if (ady >= SWIPE_MIN) begin
                    gest_d = diff_y[9] ? 5'b00100 : 5'b01000;
                end else if (adx <= TAP_MAX && ady <= TAP_MAX) begin
                    gest_d = 5'b10000;
                end
            end
            ST_ABORT:   gap_d  = report ? '0 : sat_inc(gap_q);
            ST_HOLDOFF: hold_d = sat_inc(hold_q);
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            rdy_q  <= 1'b0;
            sx_q   <= '0;
            sy_q   <= '0;
            lx_q   <= '0;
            ly_q   <= '0;
            dur_q  <= '0;
            gap_q  <= '0;
            hold_q <= '0;
            dx_q   <= '0;
            dy_q   <= '0;
            gest_q <= '0;
        end else begin
            rdy_q  <= iREADY;
            sx_q   <= sx_d;
            sy_q   <= sy_d;
            lx_q   <= lx_d;
            ly_q   <= ly_d;
            dur_q  <= dur_d;
            gap_q  <= gap_d;
            hold_q <= hold_d;
            dx_q   <= dx_d;
            dy_q   <= dy_d;
            gest_q <= gest_d;
        end
    end

    always_comb begin
        oBUSY     = (state_q != ST_IDLE);
        oGEST_W   = gest_q[0];
        oGEST_E   = gest_q[1];
        oGEST_N   = gest_q[2];
        oGEST_S   = gest_q[3];
        oGEST_TAP = gest_q[4];
        oDX       = dx_q;
        oDY       = dy_q;
    end

endmodule

// File: tb/tb_touch_swipe_decoder.sv
// Randomized stroke bench for touch_swipe_decoder with a transaction-level gesture model.
`timescale 1ns/1ps
module tb_touch_swipe_decoder;

    localparam int unsigned SWIPE_MIN = 60;
    localparam int unsigned TAP_MAX   = 15;
    localparam int unsigned GAP       = 40;
    localparam int unsigned TMO       = 300;
    localparam int unsigned HOLD      = 50;
    localparam int C_W = 0, C_E = 1, C_N = 2, C_S = 3, C_TAP = 4, C_NONE = -1;

    logic               iCLK = 1'b0;
    logic               iRSTN = 1'b0;
    logic               iREADY = 1'b0;
    logic [3:0]         iTOUCH_COUNT = '0;
    logic [9:0]         iX1 = '0;
    logic [8:0]         iY1 = '0;
    logic               oGEST_W, oGEST_E, oGEST_N, oGEST_S, oGEST_TAP, oBUSY;
    logic signed [10:0] oDX;
    logic signed [9:0]  oDY;

    touch_swipe_decoder #(
        .SWIPE_MIN     (SWIPE_MIN),
        .TAP_MAX       (TAP_MAX),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TMO),
        .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .iCLK        (iCLK),
        .iRSTN       (iRSTN),
        .iREADY      (iREADY),
        .iTOUCH_COUNT(iTOUCH_COUNT),
        .iX1         (iX1),
        .iY1         (iY1),
        .oGEST_W     (oGEST_W),
        .oGEST_E     (oGEST_E),
        .oGEST_N     (oGEST_N),
        .oGEST_S     (oGEST_S),
        .oGEST_TAP   (oGEST_TAP),
        .oDX         (oDX),
        .oDY         (oDY),
        .oBUSY       (oBUSY)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct { int cyc; int code; } pulse_t;
    typedef struct { int x; int y; int c; int sp; } rpt_t;

    pulse_t pq[$];
    rpt_t   stk[$];
    int     n_chk = 0, n_fail = 0;
    int     mdx = 0, mdy = 0;

    // Every cycle with any pulse high is logged; code 9 marks more than one pulse at once.
    always @(negedge iCLK) begin
        logic [4:0] p;
        int code;
        p = {oGEST_TAP, oGEST_S, oGEST_N, oGEST_E, oGEST_W};
        if (p != 5'd0) begin
            code = $onehot(p) ? $clog2(p) : 9;
            pq.push_back('{cyc, code});
        end
    end

    task automatic check_eq(input string tag, input logic signed [31:0] act,
                            input logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    task automatic scramble();
        iX1          = 10'($urandom_range(0, 799));
        iY1          = 9'($urandom_range(0, 479));
        iTOUCH_COUNT = 4'($urandom_range(0, 5));
    endtask

    // The report edge is the posedge just before edge_cyc is read; while iREADY stays
    // high the inputs are scrambled, which must be ignored.
    task automatic send_report(input int x, input int y, input int c, output int edge_cyc);
        int hold;
        @(negedge iCLK);
        iX1 = x[9:0];
        iY1 = y[8:0];
        iTOUCH_COUNT = c[3:0];
        iREADY = 1'b1;
        @(negedge iCLK);
        edge_cyc = cyc;
        hold = $urandom_range(0, 2);
        repeat (hold) begin
            scramble();
            @(negedge iCLK);
        end
        iREADY = 1'b0;
        scramble();
    endtask

    function automatic int classify(input int dx, input int dy);
        int ax, ay;
        ax = (dx < 0) ? -dx : dx;
        ay = (dy < 0) ? -dy : dy;
        if (ax >= ay && ax >= int'(SWIPE_MIN)) return (dx > 0) ? C_E : C_W;
        if (ay >= int'(SWIPE_MIN))              return (dy > 0) ? C_S : C_N;
        if (ax <= int'(TAP_MAX) && ay <= int'(TAP_MAX)) return C_TAP;
        return C_NONE;
    endfunction

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic add(input int x, input int y, input int c, input int sp);
        stk.push_back('{x, y, c, sp});
    endtask

    task automatic do_stroke(input string name);
        int e[$];
        int ec, sx, sy, lx, ly, last_e, dec, code;
        bit aborted;
        pq.delete();
        foreach (stk[i]) begin
            idle(stk[i].sp);
            send_report(stk[i].x, stk[i].y, stk[i].c, ec);
            e.push_back(ec);
        end
        sx = stk[0].x; sy = stk[0].y; lx = sx; ly = sy;
        last_e = e[0]; aborted = 1'b0; dec = -1;
        for (int i = 1; i < stk.size(); i++) begin
            if (stk[i].c >= 2) begin aborted = 1'b1; break; end
            if (stk[i].c == 0) begin dec = e[i]; break; end
            lx = stk[i].x; ly = stk[i].y; last_e = e[i];
        end
        if (!aborted && dec < 0) dec = last_e + int'(GAP);
        if (!aborted && e[0] + int'(TMO) < dec) aborted = 1'b1;
        code = aborted ? C_NONE : classify(lx - sx, ly - sy);
        if (!aborted) begin
            mdx = lx - sx;
            mdy = ly - sy;
        end
        idle(int'(GAP + HOLD) + 10);
        check_eq({name, ".npulse"}, pq.size(), (code == C_NONE) ? 0 : 1);
        if (code != C_NONE && pq.size() > 0) begin
            check_eq({name, ".kind"}, pq[0].code, code);
            check_eq({name, ".cycle"}, pq[0].cyc, dec + 1);
        end
        check_eq({name, ".dx"}, oDX, mdx);
        check_eq({name, ".dy"}, oDY, mdy);
        check_eq({name, ".busy"}, oBUSY, 0);
        stk.delete();
    endtask

    initial begin
        int ec, last_e, x, y, n, d;
        logic [4:0] pv;

        scramble();
        idle(3);
        pv = {oGEST_TAP, oGEST_S, oGEST_N, oGEST_E, oGEST_W};
        check_eq("rst.busy", oBUSY, 0);
        check_eq("rst.dx", oDX, 0);
        check_eq("rst.dy", oDY, 0);
        check_eq("rst.pulses", pv, 0);
        iRSTN = 1'b1;
        idle(3);

        add(100, 200, 1, 2); add(300, 210, 1, 10); add(0, 0, 0, 10);
        do_stroke("east");
        add(400, 400, 1, 2); add(390, 100, 1, 10); add(0, 0, 0, 10);
        do_stroke("north");
        add(500, 50, 1, 2); add(420, 130, 1, 10); add(0, 0, 0, 10);
        do_stroke("west_tie");

        // Tap by gap expiry, then a stroke inside holdoff that must be ignored.
        pq.delete();
        send_report(50, 50, 1, ec);
        idle(10);
        send_report(55, 58, 1, last_e);
        idle(int'(GAP) + 3);
        check_eq("tap.npulse", pq.size(), 1);
        if (pq.size() > 0) begin
            check_eq("tap.kind", pq[0].code, C_TAP);
            check_eq("tap.cycle", pq[0].cyc, last_e + int'(GAP) + 1);
        end
        mdx = 5; mdy = 8;
        send_report(100, 100, 1, ec);
        send_report(300, 100, 1, ec);
        send_report(0, 0, 0, ec);
        check_eq("holdoff.busy", oBUSY, 1);
        idle(int'(HOLD) + 10);
        check_eq("holdoff.npulse", pq.size(), 1);
        check_eq("holdoff.dx", oDX, mdx);
        check_eq("holdoff.dy", oDY, mdy);
        check_eq("holdoff.idle", oBUSY, 0);
        add(100, 100, 1, 2); add(300, 100, 1, 3); add(0, 0, 0, 3);
        do_stroke("after_holdoff");

        add(100, 100, 1, 2); add(100, 100, 2, 5); add(300, 100, 1, 5); add(0, 0, 0, 5);
        do_stroke("multi_abort");
        add(100, 100, 1, 2);
        for (int i = 0; i < 12; i++) add(100 + 20 * i, 100, 1, 30);
        add(0, 0, 0, 30);
        do_stroke("timeout");

        // Asynchronous reset between clock edges in the middle of a stroke.
        pq.delete();
        send_report(100, 100, 1, ec);
        idle(3);
        send_report(400, 100, 1, ec);
        idle(5);
        check_eq("rstmid.busy_before", oBUSY, 1);
        #2 iRSTN = 1'b0;
        #1;
        pv = {oGEST_TAP, oGEST_S, oGEST_N, oGEST_E, oGEST_W};
        check_eq("rstmid.busy", oBUSY, 0);
        check_eq("rstmid.dx", oDX, 0);
        check_eq("rstmid.dy", oDY, 0);
        check_eq("rstmid.pulses", pv, 0);
        mdx = 0; mdy = 0;
        idle(2);
        iRSTN = 1'b1;
        send_report(0, 0, 0, ec);
        idle(10);
        check_eq("rstmid.npulse", pq.size(), 0);
        check_eq("rstmid.idle", oBUSY, 0);

        for (int t = 0; t < 40; t++) begin
            x = $urandom_range(0, 799);
            y = $urandom_range(0, 479);
            add(x, y, 1, $urandom_range(2, 10));
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                case ($urandom_range(0, 2))
                    0:       d = 8;
                    1:       d = 60;
                    default: d = 400;
                endcase
                x = clampi(x + int'($urandom_range(0, 2 * d)) - d, 799);
                y = clampi(y + int'($urandom_range(0, 2 * d)) - d, 479);
                add(x, y, ($urandom_range(0, 19) == 0) ? 2 : 1, $urandom_range(2, 20));
            end
            if ($urandom_range(0, 9) < 7) add(0, 0, 0, $urandom_range(2, 20));
            do_stroke("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
